// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial add feeder and its paired serial adder.
//   DEFAULT_W : default operand width
//   state_t   : feeder FSM state encoding
package serial_add_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first. The sum bit is combinational from the current
// operand bits and the stored carry; the carry is cleared after the last bit
// so every word starts from zero.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   ser_vld               : a bit pair is present this cycle
//   ser_a, ser_b          : operand bits
//   ser_last              : final bit of the word
//   ser_sum               : sum bit for the current cycle
module serial_adder (
    input  logic clk,
    input  logic rst,
    input  logic ser_vld,
    input  logic ser_a,
    input  logic ser_b,
    input  logic ser_last,
    output logic ser_sum
);

    logic r_carry;
    logic w_carry_next;

    assign ser_sum      = ser_a ^ ser_b ^ r_carry;
    assign w_carry_next = (ser_a & ser_b) | (ser_a & r_carry) | (ser_b & r_carry);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_carry <= 1'b0;
        end else if (ser_vld) begin
            // carry out of the top bit is dropped
            r_carry <= ser_last ? 1'b0 : w_carry_next;
        end
    end

endmodule

// File: rtl/serial_add_feeder.sv
// Accepts a parallel operand pair, streams it LSB first to a serial adder,
// collects the returned sum bits into a word and presents it with a
// one-cycle valid pulse.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   in_vld / in_rdy          : operand pair handshake
//   in_a, in_b               : operands
//   in_len                   : number of bits to send minus 1
//   gap                      : stall the serial stream this cycle
//   ser_vld/ser_a/ser_b/ser_last : serial stream to the adder
//   ser_sum                  : adder sum bit for the current cycle
//   res_vld / res_sum        : collected result
//
// state | meaning
// IDLE  | ready for a new operand pair
// SHIFT | streaming bits, one per non-gap cycle
// DONE  | result valid for one cycle
module serial_add_feeder
    import serial_add_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [W-1:0]         in_a,
    input  logic [W-1:0]         in_b,
    input  logic [$clog2(W)-1:0] in_len,
    input  logic                 gap,
    output logic                 ser_vld,
    output logic                 ser_a,
    output logic                 ser_b,
    output logic                 ser_last,
    input  logic                 ser_sum,
    output logic                 res_vld,
    output logic [W-1:0]         res_sum
);

    localparam int LW = $clog2(W);

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_cnt;
    logic [W-1:0]    r_res_sum;

    assign res_sum = r_res_sum;

    always_comb begin
        w_next_state = r_state;
        in_rdy       = 1'b0;
        ser_vld      = 1'b0;
        ser_a        = 1'b0;
        ser_b        = 1'b0;
        ser_last     = 1'b0;
        res_vld      = 1'b0;
        case (r_state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                ser_vld  = ~gap;
                ser_a    = r_a[0];
                ser_b    = r_b[0];
                ser_last = ~gap & (r_cnt == r_len);
                if (~gap & (r_cnt == r_len)) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                res_vld      = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_res_sum <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_vld) begin
                        r_a       <= in_a;
                        r_b       <= in_b;
                        r_len     <= in_len;
                        r_cnt     <= '0;
                        r_res_sum <= '0;
                    end
                end
                SHIFT: begin
                    if (!gap) begin
                        r_res_sum[r_cnt] <= ser_sum;
                        r_a              <= r_a >> 1;
                        r_b              <= r_b >> 1;
                        r_cnt            <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_feeder.sv
module tb_serial_add_feeder;
    import serial_add_pkg::*;

    localparam int W  = 8;
    localparam int LW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [LW-1:0] in_len = '0;
    logic          gap;
    logic          gap_man = 1'b0;
    logic          gap_rand = 1'b0;
    logic          gap_rand_en = 1'b0;
    logic          ser_vld, ser_a, ser_b, ser_last, ser_sum;
    logic          res_vld;
    logic [W-1:0]  res_sum;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           len;
        logic [W-1:0] sum;
    } word_t;

    word_t sb_q[$];

    assign gap = gap_rand_en ? gap_rand : gap_man;

    always #5 clk = ~clk;

    serial_add_feeder #(.W(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_len   (in_len),
        .gap      (gap),
        .ser_vld  (ser_vld),
        .ser_a    (ser_a),
        .ser_b    (ser_b),
        .ser_last (ser_last),
        .ser_sum  (ser_sum),
        .res_vld  (res_vld),
        .res_sum  (res_sum)
    );

    serial_adder u_adder (
        .clk      (clk),
        .rst      (rst),
        .ser_vld  (ser_vld),
        .ser_a    (ser_a),
        .ser_b    (ser_b),
        .ser_last (ser_last),
        .ser_sum  (ser_sum)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input int len);
        logic [31:0] full;
        logic [31:0] mask;
        full = 32'(a) + 32'(b);
        mask = (32'd1 << (len + 1)) - 32'd1;
        return W'(full & mask);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input int len, input bit keep);
        word_t w;
        int    n;
        w.a   = a;
        w.b   = b;
        w.len = len;
        w.sum = ref_sum(a, b, len);
        sb_q.push_back(w);
        in_a   = a;
        in_b   = b;
        in_len = LW'(len);
        in_vld = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=no_accept required=accept t=%0t", $time);
                finish_run();
            end
        end
        next_cycle();
        if (!keep) begin
            in_vld = 1'b0;
            in_a   = W'($urandom);
            in_b   = W'($urandom);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            gap_rand = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: walks the expected bit sequence of the word at the head of the
    // scoreboard and compares every DUT output each cycle.
    initial begin
        int           phase;
        int           bit_i;
        word_t        cur;
        logic [W-1:0] last_sum;
        logic [31:0]  mask;
        phase    = 0;
        bit_i    = 0;
        last_sum = '0;
        cur      = '{a: '0, b: '0, len: 0, sum: '0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_in_rdy",   32'(in_rdy),   32'd1);
                check("rst_ser_vld",  32'(ser_vld),  32'd0);
                check("rst_ser_a",    32'(ser_a),    32'd0);
                check("rst_ser_b",    32'(ser_b),    32'd0);
                check("rst_ser_last", 32'(ser_last), 32'd0);
                check("rst_res_vld",  32'(res_vld),  32'd0);
                check("rst_res_sum",  32'(res_sum),  32'd0);
                if (phase != 0 && sb_q.size() > 0) void'(sb_q.pop_front());
                phase    = 0;
                last_sum = '0;
            end else begin
                case (phase)
                    0: begin
                        check("idle_in_rdy",   32'(in_rdy),   32'd1);
                        check("idle_ser_vld",  32'(ser_vld),  32'd0);
                        check("idle_ser_a",    32'(ser_a),    32'd0);
                        check("idle_ser_b",    32'(ser_b),    32'd0);
                        check("idle_ser_last", 32'(ser_last), 32'd0);
                        check("idle_res_vld",  32'(res_vld),  32'd0);
                        check("idle_res_hold", 32'(res_sum),  32'(last_sum));
                        if (in_vld) begin
                            if (sb_q.size() == 0) begin
                                check("sb_nonempty", 32'd0, 32'd1);
                            end else begin
                                cur   = sb_q[0];
                                phase = 1;
                                bit_i = 0;
                            end
                        end
                    end
                    1: begin
                        mask = (32'd1 << bit_i) - 32'd1;
                        check("shift_in_rdy",  32'(in_rdy),  32'd0);
                        check("shift_res_vld", 32'(res_vld), 32'd0);
                        check("shift_ser_a",   32'(ser_a),   32'(cur.a[bit_i]));
                        check("shift_ser_b",   32'(ser_b),   32'(cur.b[bit_i]));
                        check("shift_partial", 32'(res_sum), 32'(cur.sum) & mask);
                        if (gap) begin
                            check("gap_ser_vld",  32'(ser_vld),  32'd0);
                            check("gap_ser_last", 32'(ser_last), 32'd0);
                        end else begin
                            check("bit_ser_vld",  32'(ser_vld),  32'd1);
                            check("bit_ser_last", 32'(ser_last), 32'(bit_i == cur.len));
                            bit_i++;
                            if (bit_i > cur.len) phase = 2;
                        end
                    end
                    default: begin
                        check("done_res_vld", 32'(res_vld), 32'd1);
                        check("done_res_sum", 32'(res_sum), 32'(cur.sum));
                        check("done_in_rdy",  32'(in_rdy),  32'd0);
                        check("done_ser_vld", 32'(ser_vld), 32'd0);
                        if (sb_q.size() > 0) void'(sb_q.pop_front());
                        last_sum = cur.sum;
                        phase    = 0;
                    end
                endcase
            end
        end
    end

    initial begin
        int n;
        #1 rst = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b1;
        repeat (2) next_cycle();

        send_word(8'h35, 8'h0A, 7, 1'b0);
        send_word(8'hFF, 8'h01, 7, 1'b0);
        send_word(8'h0D, 8'h05, 3, 1'b0);
        send_word(8'h23, 8'h11, 0, 1'b0);
        send_word(8'h01, 8'h01, 0, 1'b0);

        // bubbles on bit cycles 2 and 5
        send_word(8'h35, 8'h0A, 7, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            gap_man = (k == 2 || k == 5);
            next_cycle();
        end
        gap_man = 1'b0;

        // second word offered while the first is in flight
        send_word(8'h12, 8'h34, 7, 1'b1);
        send_word(8'h80, 8'h80, 7, 1'b0);

        // reset during bit 4, then a clean word
        send_word(8'h35, 8'h0A, 7, 1'b0);
        repeat (3) next_cycle();
        rst = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
        send_word(8'h35, 8'h0A, 7, 1'b0);

        gap_rand_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_word(W'($urandom), W'($urandom), int'($urandom_range(0, W - 1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                in_vld = 1'b0;
                repeat ($urandom_range(1, 3)) next_cycle();
            end
        end
        in_vld = 1'b0;

        n = 0;
        while (sb_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        repeat (3) next_cycle();
        finish_run();
    end

endmodule
